// File: rtl/uart_frame_tx_gen.sv
// UART frame transmitter: HEADER, payload bytes, CRC-8 over the payload, TRAILER,
// serialised 8N1 on one line with an optional idle gap between bytes.
module uart_frame_tx_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned MAX_LEN  = 10,
  parameter logic [7:0]  HEADER   = 8'h80,
  parameter logic [7:0]  TRAILER  = 8'h55,
  parameter logic [7:0]  CRC_POLY = 8'h07,
  parameter logic [7:0]  CRC_INIT = 8'h00,
  parameter int unsigned GAP_CLKS = 0,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   tx_start,
  input  logic [LW-1:0]          tx_len,
  input  logic [8*MAX_LEN-1:0]   tx_payload,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_len_err,
  output logic                   tx_drop,
  output logic [7:0]             crc_out,
  output logic [2:0]             frame_state
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [LW-1:0] MAX_L    = LW'(MAX_LEN);
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CLKS - 1);

  typedef enum logic [2:0] {F_IDLE, F_HDR, F_PAY, F_CRC, F_TRL} frame_t;
  typedef enum logic [1:0] {B_START, B_DATA, B_STOP, B_GAP} phase_t;

  frame_t               frame_st;
  frame_t               next_frame;
  phase_t               phase;
  logic [CW-1:0]        clk_cnt;
  logic [15:0]          gap_cnt;
  logic [2:0]           bit_idx;
  logic [LW-1:0]        byte_idx;
  logic [LW-1:0]        len_reg;
  logic [7:0]           shreg;
  logic [7:0]           crc_reg;
  logic [7:0]           next_byte;
  logic [8*MAX_LEN-1:0] pay_reg;
  logic                 bit_end;
  logic                 gap_end;
  logic                 load_next;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign frame_state = frame_st;

  // Next byte on the line; pay_reg is shifted down so its low byte is always the next payload byte.
  always_comb begin
    bit_end    = (clk_cnt == BIT_LAST);
    gap_end    = (gap_cnt == GAP_LAST);
    load_next  = 1'b0;
    next_frame = F_TRL;
    next_byte  = TRAILER;
    if (tx_busy) begin
      if (phase == B_STOP && bit_end && frame_st != F_TRL && GAP_CLKS == 0) load_next = 1'b1;
      if (phase == B_GAP && gap_end) load_next = 1'b1;
    end
    case (frame_st)
      F_HDR: begin
        if (len_reg == '0) begin
          next_frame = F_CRC;
          next_byte  = crc_reg;
        end else begin
          next_frame = F_PAY;
          next_byte  = pay_reg[7:0];
        end
      end
      F_PAY: begin
        if (byte_idx == LW'(len_reg - 1'b1)) begin
          next_frame = F_CRC;
          next_byte  = crc_reg;
        end else begin
          next_frame = F_PAY;
          next_byte  = pay_reg[7:0];
        end
      end
      default: begin
        next_frame = F_TRL;
        next_byte  = TRAILER;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      frame_st   <= F_IDLE;
      phase      <= B_START;
      clk_cnt    <= '0;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      len_reg    <= '0;
      shreg      <= '0;
      crc_reg    <= CRC_INIT;
      pay_reg    <= '0;
      uart_txd   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_len_err <= 1'b0;
      tx_drop    <= 1'b0;
      crc_out    <= CRC_INIT;
    end else begin
      tx_done    <= 1'b0;
      tx_len_err <= 1'b0;
      tx_drop    <= tx_start && tx_busy;
      if (frame_st == F_IDLE) begin
        if (tx_start) begin
          frame_st   <= F_HDR;
          phase      <= B_START;
          clk_cnt    <= '0;
          shreg      <= HEADER;
          crc_reg    <= CRC_INIT;
          pay_reg    <= tx_payload;
          len_reg    <= (tx_len > MAX_L) ? MAX_L : tx_len;
          tx_len_err <= (tx_len > MAX_L);
          tx_busy    <= 1'b1;
          uart_txd   <= 1'b0;
        end
      end else begin
        if (phase == B_GAP) gap_cnt <= gap_cnt + 16'd1;
        else if (bit_end)   clk_cnt <= '0;
        else                clk_cnt <= clk_cnt + 1'b1;
        case (phase)
          B_START: if (bit_end) begin
            phase    <= B_DATA;
            bit_idx  <= '0;
            uart_txd <= shreg[0];
          end
          B_DATA: if (bit_end) begin
            if (bit_idx == 3'd7) begin
              phase    <= B_STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shreg[1];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end
          B_STOP: if (bit_end) begin
            if (frame_st == F_TRL) begin
              frame_st <= F_IDLE;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else if (GAP_CLKS != 0) begin
              phase   <= B_GAP;
              gap_cnt <= '0;
            end
          end
          default: ;
        endcase
        if (load_next) begin
          phase    <= B_START;
          clk_cnt  <= '0;
          uart_txd <= 1'b0;
          shreg    <= next_byte;
          frame_st <= next_frame;
          if (next_frame == F_PAY) begin
            pay_reg  <= pay_reg >> 8;
            crc_reg  <= crc8_step(crc_reg, pay_reg[7:0]);
            byte_idx <= (frame_st == F_HDR) ? '0 : byte_idx + 1'b1;
          end
          if (next_frame == F_CRC) crc_out <= crc_reg;
        end
      end
    end
  end

endmodule
